mac_acc_seq: RTL and testbench

MAC_ACC_SEQ -- requirements
Module: mac_acc_seq

---
 rtl/mac_acc_seq_pkg.sv | 27 ++
 rtl/mac_acc_seq_add.sv | 13 +
 rtl/mac_acc_seq.sv | 134 +++++++++++++
 tb/tb_mac_acc_seq.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_acc_seq_pkg.sv
// Shared MAC header: default widths, the accumulator FSM state type and a
// ceiling-log2 helper used to size counters.
package mac_acc_seq_pkg;

    localparam int MAC_DEF_M = 8;
    localparam int MAC_DEF_N = 32;
    localparam int MAC_DEF_K = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } mac_state_t;

    // Ceiling log2; log2c(1) is 0, so callers add 1 where a zero width is possible.
    function automatic int log2c(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_acc_seq_add.sv
// Shared W-bit unsigned adder with carry-out.
module mac_acc_seq_add #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/mac_acc_seq.sv
// Bit-serial product accumulator: collects K serial 2M-bit products LSB first
// and presents their N-bit modulo sum with a sticky carry-out flag.
module mac_acc_seq
    import mac_acc_seq_pkg::*;
#(
    parameter int M = MAC_DEF_M,
    parameter int N = MAC_DEF_N,
    parameter int K = MAC_DEF_K
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         bit_vld,
    input  logic         bit_in,
    input  logic         res_rdy,
    output logic         busy,
    output logic         res_vld,
    output logic [N-1:0] res,
    output logic         ovf
);

    localparam int PW = 2 * M;
    localparam int BW = log2c(PW);
    localparam int TW = log2c(K) + 1;
    localparam logic [BW-1:0] BIT_LAST  = BW'(PW - 1);
    localparam logic [TW-1:0] TERM_LAST = TW'(K - 1);

    mac_state_t state;
    mac_state_t state_next;

    // The top product bit arrives live on bit_in, so only 2M-1 bits need storage.
    logic [PW-2:0] prod;
    logic [PW-1:0] word;
    logic [N-1:0]  word_ext;
    logic [BW-1:0] bit_cnt;
    logic [TW-1:0] term_cnt;
    logic [N-1:0]  acc;
    logic [N-1:0]  sum;
    logic          carry;
    logic          clear;
    logic          shift;
    logic          accumulate;

    assign word = {bit_in, prod};

    always_comb begin
        word_ext          = '0;
        word_ext[PW-1:0]  = word;
    end

    mac_acc_seq_add #(
        .W(N)
    ) u_add (
        .a   (acc),
        .b   (word_ext),
        .sum (sum),
        .cout(carry)
    );

    always_comb begin
        state_next = state;
        clear      = 1'b0;
        shift      = 1'b0;
        accumulate = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = COLLECT;
                    clear      = 1'b1;
                end
            end
            COLLECT: begin
                // A restart takes priority over any bit offered in the same cycle.
                if (start) begin
                    clear = 1'b1;
                end else if (bit_vld) begin
                    shift = 1'b1;
                    if (bit_cnt == BIT_LAST) begin
                        accumulate = 1'b1;
                        if (term_cnt == TERM_LAST) begin
                            state_next = DONE;
                        end
                    end
                end
            end
            DONE: begin
                if (res_rdy) begin
                    if (start) begin
                        state_next = COLLECT;
                        clear      = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            prod     <= '0;
            bit_cnt  <= '0;
            term_cnt <= '0;
            acc      <= '0;
            ovf      <= 1'b0;
        end else begin
            state <= state_next;
            if (clear) begin
                prod     <= '0;
                bit_cnt  <= '0;
                term_cnt <= '0;
                acc      <= '0;
                ovf      <= 1'b0;
            end else if (shift) begin
                prod <= word[PW-1:1];
                if (accumulate) begin
                    bit_cnt  <= '0;
                    term_cnt <= term_cnt + TW'(1);
                    acc      <= sum;
                    ovf      <= ovf | carry;
                end else begin
                    bit_cnt <= bit_cnt + BW'(1);
                end
            end
        end
    end

    assign busy    = (state == COLLECT);
    assign res_vld = (state == DONE);
    assign res     = acc;

endmodule

// File: tb/tb_mac_acc_seq.sv
// Scoreboard bench for mac_acc_seq: directed product streams push expected
// sums, a negedge monitor compares whenever a result is presented.
module tb_mac_acc_seq;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, bit_vld_a, bit_in_a, res_rdy_a;
    logic        busy_a, res_vld_a, ovf_a;
    logic [31:0] res_a;
    logic        start_b, bit_vld_b, bit_in_b, res_rdy_b;
    logic        busy_b, res_vld_b, ovf_b;
    logic [15:0] res_b;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   last_cyc = 0;
    bit   prev_vld[2];
    bit   after_hs[2];

    mac_acc_seq #(.M(8), .N(32), .K(4)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .bit_vld(bit_vld_a), .bit_in(bit_in_a),
        .res_rdy(res_rdy_a), .busy(busy_a), .res_vld(res_vld_a), .res(res_a), .ovf(ovf_a)
    );

    mac_acc_seq #(.M(8), .N(16), .K(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .bit_vld(bit_vld_b), .bit_in(bit_in_b),
        .res_rdy(res_rdy_b), .busy(busy_b), .res_vld(res_vld_b), .res(res_b), .ovf(ovf_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int w);
        return (w == 0) ? q_a.size() : q_b.size();
    endfunction

    task automatic monitor(input int w, input logic vld, input logic [31:0] r, input logic o, input logic rdy);
        exp_t  e;
        string pre;
        pre = (w == 0) ? "a_" : "b_";
        if (after_hs[w]) begin
            check_output({pre, "vld_after_handshake"}, 32'(vld), 32'd0);
            after_hs[w] = 1'b0;
        end
        if (vld) begin
            if (qsize(w) == 0) begin
                check_output({pre, "unexpected_res_vld"}, 32'(vld), 32'd0);
            end else begin
                e = (w == 0) ? q_a[0] : q_b[0];
                if (!prev_vld[w]) check_output({pre, "latency_cycle"}, 32'(cyc), 32'(e.cyc));
                check_output({pre, "res"}, r, e.res);
                check_output({pre, "ovf"}, 32'(o), 32'(e.ovf));
                if (rdy) begin
                    if (w == 0) void'(q_a.pop_front());
                    else        void'(q_b.pop_front());
                    after_hs[w] = 1'b1;
                end
            end
        end
        prev_vld[w] = vld;
    endtask

    always @(negedge clk) begin
        monitor(0, res_vld_a, res_a, ovf_a, res_rdy_a);
        monitor(1, res_vld_b, {16'h0, res_b}, ovf_b, res_rdy_b);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int w, input logic s, input logic v, input logic b);
        if (w == 0) begin
            start_a = s; bit_vld_a = v; bit_in_a = b;
        end else begin
            start_b = s; bit_vld_b = v; bit_in_b = b;
        end
    endtask

    task automatic pulse_start(input int w, input logic v, input logic b);
        set_in(w, 1'b1, v, b);
        step();
        set_in(w, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_bits(input int w, input int count, input logic b);
        for (int i = 0; i < count; i++) begin
            set_in(w, 1'b0, 1'b1, b);
            step();
        end
        set_in(w, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_product(input int w, input logic [15:0] p, input int max_gap);
        for (int i = 0; i < 16; i++) begin
            if (max_gap > 0) begin
                repeat ($urandom_range(max_gap, 0)) begin
                    set_in(w, 1'b0, 1'b0, 1'b0);
                    step();
                end
            end
            set_in(w, 1'b0, 1'b1, p[i]);
            last_cyc = cyc;
            step();
        end
        set_in(w, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic expect_result(input int w, input logic [31:0] r, input logic o);
        exp_t e;
        e.res = r;
        e.ovf = o;
        e.cyc = last_cyc + 1;
        if (w == 0) q_a.push_back(e);
        else        q_b.push_back(e);
    endtask

    task automatic wait_drain(input int w);
        int n;
        n = 0;
        while (qsize(w) != 0 && n < 50) begin
            step();
            n++;
        end
        check_output((w == 0) ? "a_drain_pending" : "b_drain_pending", 32'(qsize(w)), 32'd0);
        if (w == 0) q_a.delete();
        else        q_b.delete();
    endtask

    task automatic apply_stimulus();
        // Four contiguous products
        pulse_start(0, 1'b0, 1'b0);
        check_output("busy_after_start", 32'(busy_a), 32'd1);
        send_product(0, 16'd3, 0);
        send_product(0, 16'd5, 0);
        send_product(0, 16'd7, 0);
        send_product(0, 16'd9, 0);
        expect_result(0, 32'd24, 1'b0);
        wait_drain(0);

        // Same stream with idle gaps between bits
        pulse_start(0, 1'b0, 1'b0);
        send_product(0, 16'd3, 3);
        send_product(0, 16'd5, 3);
        send_product(0, 16'd7, 3);
        send_product(0, 16'd9, 3);
        expect_result(0, 32'd24, 1'b0);
        wait_drain(0);

        // Stall in DONE, with an ignored start, then handshake to IDLE
        res_rdy_a = 1'b0;
        pulse_start(0, 1'b0, 1'b0);
        send_product(0, 16'd1, 0);
        send_product(0, 16'd2, 0);
        send_product(0, 16'd3, 0);
        send_product(0, 16'd4, 0);
        expect_result(0, 32'd10, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check_output("stall_res_vld", 32'(res_vld_a), 32'd1);
            if (i == 2) start_a = 1'b1;
            step();
            start_a = 1'b0;
        end
        res_rdy_a = 1'b1;
        step();
        check_output("idle_busy", 32'(busy_a), 32'd0);
        check_output("idle_res_vld", 32'(res_vld_a), 32'd0);
        wait_drain(0);

        // Handshake with start goes straight back to COLLECT
        res_rdy_a = 1'b0;
        pulse_start(0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_product(0, 16'd2, 0);
        expect_result(0, 32'd8, 1'b0);
        res_rdy_a = 1'b1;
        set_in(0, 1'b1, 1'b0, 1'b0);
        step();
        set_in(0, 1'b0, 1'b0, 1'b0);
        check_output("hs_start_busy", 32'(busy_a), 32'd1);
        send_product(0, 16'd6, 0);
        send_product(0, 16'd7, 0);
        send_product(0, 16'd8, 0);
        send_product(0, 16'd9, 0);
        expect_result(0, 32'd30, 1'b0);
        wait_drain(0);

        // Restart after 20 bits; the coincident bit must be dropped
        pulse_start(0, 1'b0, 1'b0);
        send_bits(0, 20, 1'b1);
        pulse_start(0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) send_product(0, 16'd1, 0);
        expect_result(0, 32'd4, 1'b0);
        wait_drain(0);

        // Reset in the middle of collection, then bits without a start
        pulse_start(0, 1'b0, 1'b0);
        send_product(0, 16'hFFFF, 0);
        send_bits(0, 14, 1'b1);
        rst = 1'b0;
        #1;
        check_output("rst_mid_busy", 32'(busy_a), 32'd0);
        check_output("rst_mid_res_vld", 32'(res_vld_a), 32'd0);
        check_output("rst_mid_res", res_a, 32'd0);
        check_output("rst_mid_ovf", 32'(ovf_a), 32'd0);
        step();
        rst = 1'b1;
        step();
        send_bits(0, 64, 1'b1);
        check_output("no_start_busy", 32'(busy_a), 32'd0);
        check_output("no_start_res_vld", 32'(res_vld_a), 32'd0);
        pulse_start(0, 1'b0, 1'b0);
        send_product(0, 16'h1000, 0);
        send_product(0, 16'h0200, 0);
        send_product(0, 16'h0030, 0);
        send_product(0, 16'h0004, 0);
        expect_result(0, 32'd4660, 1'b0);
        wait_drain(0);

        // Narrow accumulator overflow, then ovf cleared by the next start
        pulse_start(1, 1'b0, 1'b0);
        send_product(1, 16'd65025, 0);
        send_product(1, 16'd65025, 0);
        expect_result(1, 32'd64514, 1'b1);
        wait_drain(1);
        pulse_start(1, 1'b0, 1'b0);
        send_product(1, 16'd1, 0);
        send_product(1, 16'd2, 0);
        expect_result(1, 32'd3, 1'b0);
        wait_drain(1);
    endtask

    initial begin
        rst = 1'b0;
        set_in(0, 1'b0, 1'b0, 1'b0);
        set_in(1, 1'b0, 1'b0, 1'b0);
        res_rdy_a = 1'b1;
        res_rdy_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_busy", 32'(busy_a), 32'd0);
        check_output("reset_res_vld", 32'(res_vld_a), 32'd0);
        check_output("reset_res", res_a, 32'd0);
        check_output("reset_ovf", 32'(ovf_a), 32'd0);
        rst = 1'b1;
        step();
        apply_stimulus();
        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog");
    end

endmodule
